// File: rtl/imem_boot_loader_pkg.sv
// Shared types and constants for the boot loader.
// The frame starts with a 2-byte word count, followed by 4 little-endian bytes per word.
package imem_boot_loader_pkg;

  typedef enum logic [2:0] {
    LEN0,
    LEN1,
    DATA,
    WRITE_LAST,
    DONE,
    ERR
  } state_t;

  localparam int LEN_BYTES      = 2;
  localparam int BYTES_PER_WORD = 4;

endpackage

// File: rtl/imem_boot_loader_word_assembler.sv
// Collects 4 little-endian bytes into a word. word_valid pulses 1 cycle after the 4th byte.
// There is no backpressure: the caller only presents bytes it has already accepted.
module word_assembler
  import imem_boot_loader_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clr,
  input  logic        byte_fire,
  input  logic [7:0]  byte_data,
  output logic        last_byte,
  output logic        word_valid,
  output logic [31:0] word
);

  logic [1:0] cnt;

  assign last_byte = (cnt == 2'(BYTES_PER_WORD - 1));

  // Each byte shifts in at the top, so after four bytes the first one sits in [7:0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
    end else begin
      word_valid <= byte_fire && last_byte;
      if (clr) begin
        cnt <= '0;
      end else if (byte_fire) begin
        word <= {byte_data, word[31:8]};
        cnt  <= cnt + 2'd1;
      end
    end
  end

endmodule

// File: rtl/imem_boot_loader.sv
// Boot loader: takes a length-prefixed byte stream and writes it into instruction memory from address 0.
// A write follows 1 cycle after each 4th byte. Ready drops once the last word is taken, and the core stays in reset until done.
module imem_boot_loader
  import imem_boot_loader_pkg::*;
#(
  parameter int N = 10
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         load_start_i,
  input  logic         byte_valid_i,
  input  logic [7:0]   byte_data_i,
  output logic         byte_ready_o,
  output logic         imem_we_o,
  output logic [N-1:0] imem_addr_o,
  output logic [31:0]  imem_wdata_o,
  output logic         core_rst_n_o,
  output logic         load_done_o,
  output logic         load_err_o,
  output logic [N-2:0] words_loaded_o
);

  localparam logic [15:0] CAPACITY = 16'(1 << (N - 2));

  state_t      state;
  logic [15:0] len;
  logic [15:0] len_full;
  logic        fire;
  logic        data_fire;
  logic        last_byte;
  logic        final_word;
  logic        word_valid;
  logic [31:0] word;

  assign fire       = byte_valid_i && byte_ready_o;
  assign data_fire  = fire && (state == DATA);
  assign len_full   = {byte_data_i, len[7:0]};
  assign final_word = (16'(words_loaded_o) + 16'd1) == len;

  word_assembler u_asm (
    .clk        (clk),
    .rst_n      (rst_n),
    .clr        (fire && (state == LEN1)),
    .byte_fire  (data_fire),
    .byte_data  (byte_data_i),
    .last_byte  (last_byte),
    .word_valid (word_valid),
    .word       (word)
  );

  // The word counter also serves as the write index, so the address is the count before it increments.
  assign imem_we_o    = word_valid;
  assign imem_wdata_o = word;
  assign imem_addr_o  = {words_loaded_o[N-3:0], 2'b00};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= LEN0;
      len            <= '0;
      byte_ready_o   <= 1'b0;
      core_rst_n_o   <= 1'b0;
      load_done_o    <= 1'b0;
      load_err_o     <= 1'b0;
      words_loaded_o <= '0;
    end else begin
      if (word_valid) words_loaded_o <= words_loaded_o + 1'b1;
      case (state)
        LEN0: begin
          byte_ready_o <= 1'b1;
          if (fire) begin
            len[7:0] <= byte_data_i;
            state    <= LEN1;
          end
        end
        LEN1: begin
          if (fire) begin
            len[15:8]      <= byte_data_i;
            words_loaded_o <= '0;
            if (len_full == 16'd0) begin
              state        <= DONE;
              byte_ready_o <= 1'b0;
              load_done_o  <= 1'b1;
              core_rst_n_o <= 1'b1;
            end else if (len_full > CAPACITY) begin
              state        <= ERR;
              byte_ready_o <= 1'b0;
              load_err_o   <= 1'b1;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          // Stop accepting bytes as soon as the last word is complete, so the stream cannot overrun the image.
          if (data_fire && last_byte && final_word) begin
            state        <= WRITE_LAST;
            byte_ready_o <= 1'b0;
          end
        end
        WRITE_LAST: begin
          state        <= DONE;
          load_done_o  <= 1'b1;
          core_rst_n_o <= 1'b1;
        end
        DONE, ERR: begin
          if (load_start_i) begin
            state          <= LEN0;
            byte_ready_o   <= 1'b1;
            load_done_o    <= 1'b0;
            load_err_o     <= 1'b0;
            core_rst_n_o   <= 1'b0;
            words_loaded_o <= '0;
          end
        end
        default: begin
          state        <= LEN0;
          byte_ready_o <= 1'b0;
        end
      endcase
    end
  end

endmodule
